// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: drives a one-round subkey generator
// ten times and keeps RK[0..10]. Optional watchdog: KEY_SCHED_TIMEOUT_EN.
module aes_key_sched_ctrl #(
    parameter int KEY_LEN     = 128,
    parameter int WORD_LEN    = 32,
    parameter int NUM_ROUNDS  = 10,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_LEN-1:0]  key_in,
    input  logic                start,
    output logic                busy,
    output logic                key_ready,
    output logic [WORD_LEN-1:0] gsk_rcon,
    output logic [KEY_LEN-1:0]  gsk_data,
    output logic                gsk_valid_in,
    input  logic [KEY_LEN-1:0]  gsk_data_out,
    input  logic                gsk_valid_out,
    input  logic [3:0]          rk_idx,
    output logic [KEY_LEN-1:0]  rk_data
`ifdef KEY_SCHED_TIMEOUT_EN
    ,
    output logic                err
`endif
);

    if (KEY_LEN != 128 || WORD_LEN < 8 || NUM_ROUNDS != 10 ||
        TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("aes_key_sched_ctrl: unsupported configuration");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
    localparam logic [WORD_LEN-1:0] RCON_FIRST =
        {8'h01, {(WORD_LEN-8){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_round;
    logic                  r_busy;
    logic                  r_key_ready;
    logic                  r_valid_in;
    logic [WORD_LEN-1:0]   r_rcon;
    logic [KEY_LEN-1:0]    r_data;
    logic [KEY_LEN-1:0]    r_rk_data;
    logic [KEY_LEN-1:0]    r_rk [0:NUM_ROUNDS];

    logic                  w_load;
    logic                  w_cap;
    logic                  w_rd_ok;

`ifdef KEY_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]         r_to;
    logic                  r_err;
    assign err = r_err;
`endif

    // GF(2^8) doubling used to step the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    assign w_load  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_cap   = gsk_valid_out && (r_state == S_WAIT);
    assign w_rd_ok = (rk_idx <= LAST_IDX);

    assign busy         = r_busy;
    assign key_ready    = r_key_ready;
    assign gsk_valid_in = r_valid_in;
    assign gsk_rcon     = r_rcon;
    assign gsk_data     = r_data;
    assign rk_data      = r_rk_data;

    // Control FSM: load, issue one request per round, capture, finish
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_round     <= 4'd0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b0;
            r_valid_in  <= 1'b0;
            r_rcon      <= '0;
            r_data      <= '0;
`ifdef KEY_SCHED_TIMEOUT_EN
            r_to        <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_load) begin
                        r_data      <= key_in;
                        r_round     <= 4'd1;
                        r_rcon      <= RCON_FIRST;
                        r_key_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_valid_in  <= 1'b1;
                        r_state     <= S_ISSUE;
`ifdef KEY_SCHED_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    r_valid_in <= 1'b0;
                    r_state    <= S_WAIT;
`ifdef KEY_SCHED_TIMEOUT_EN
                    r_to       <= '0;
`endif
                end
                S_WAIT: begin
                    if (gsk_valid_out) begin
                        r_data <= gsk_data_out;
                        r_rcon <= {xtime(r_rcon[WORD_LEN-1 -: 8]),
                                   {(WORD_LEN-8){1'b0}}};
                        if (r_round == LAST_IDX) begin
                            r_busy      <= 1'b0;
                            r_key_ready <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_round    <= r_round + 4'd1;
                            r_valid_in <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
`ifdef KEY_SCHED_TIMEOUT_EN
                    else if (r_to == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Round-key store; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_rk[0] <= key_in;
        end else if (w_cap) begin
            r_rk[r_round] <= gsk_data_out;
        end
    end

    // Registered read port; indices past the last round read as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rk_data <= '0;
        end else if (w_rd_ok) begin
            r_rk_data <= r_rk[rk_idx];
        end else begin
            r_rk_data <= '0;
        end
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequences the single-round subkey generator (GenSubKey) through the 10 rounds of AES-128 key expansion.
- Supplies Rcon and the previous round key to the generator, one request at a time.
- Captures each returned round key into an internal 11-entry round-key store, RK[0..10].
- Sits between the key-load interface and the cipher round datapath, which reads round keys by index.

Parameters:
- KEY_LEN, 128, round-key width; only 128 is supported.
- WORD_LEN, 32, Rcon word width.
- NUM_ROUNDS, 10, number of generated round keys; RK[0] is the cipher key.
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- key_in  input  KEY_LEN  cipher key, sampled on an accepted start.
- start  input  1  request a new expansion; accepted only in IDLE or DONE.
- busy  output  1  high while an expansion is in progress.
- key_ready  output  1  high once all 11 round keys are valid; stays high until the next accepted start or reset.
- gsk_rcon  output  WORD_LEN  Rcon to the generator; byte value in [31:24], zeros in [23:0].
- gsk_data  output  KEY_LEN  previous round key to the generator.
- gsk_valid_in  output  1  one-cycle request pulse to the generator.
- gsk_data_out  input  KEY_LEN  generated round key.
- gsk_valid_out  input  1  generated key valid.
- rk_idx  input  4  round-key read index.
- rk_data  output  KEY_LEN  registered read data: RK[rk_idx] one cycle after rk_idx is presented.
- err  output  1  sticky timeout flag; exists only with the optional feature.

Behaviour:
- Reset values: busy=0, key_ready=0, gsk_valid_in=0, gsk_rcon=0, gsk_data=0, rk_data=0, err=0, round counter=0, state=IDLE. The RK store is not cleared.
- IDLE/DONE, start=1:
  - RK[0] <= key_in; gsk_data <= key_in; round <= 1; rcon byte <= 0x01.
  - key_ready <= 0, busy <= 1, go to ISSUE.
- ISSUE:
  - Drive gsk_valid_in=1 for exactly one cycle with gsk_rcon and gsk_data stable, then go to WAIT.
  - gsk_rcon and gsk_data hold their values until the next ISSUE.
- WAIT:
  - Wait for gsk_valid_out=1. Generator latency is not fixed; any latency of 1 cycle or more is legal.
  - On gsk_valid_out: RK[round] <= gsk_data_out; gsk_data <= gsk_data_out.
  - rcon byte <= xtime(rcon): shift left 1; if bit 7 was set, XOR with 0x1B. The resulting sequence is 01,02,04,08,10,20,40,80,1B,36.
  - If round==NUM_ROUNDS go to DONE; else round <= round+1 and go to ISSUE.
- DONE: busy=0, key_ready=1.
- The next request issues no earlier than 1 cycle after capture, so requests never overlap.
- gsk_valid_out outside WAIT is ignored; it causes no capture and no state change.
- start while busy is ignored; the expansion in progress continues unchanged.
- start and gsk_valid_out in the same cycle in WAIT: the capture proceeds and start is dropped.
- Reset mid-expansion: return to IDLE with the reset values above. A late gsk_valid_out after reset is ignored.
- Read port:
  - rk_idx 0..10 returns RK[rk_idx]; rk_idx 11..15 returns 0.
  - Reads are legal at any time. During expansion they return stale or partial contents; consumers must gate on key_ready.
- Minimum expansion time: 1 (load) + 10 × (1 issue + L generator latency) cycles.

Optional Feature:
- Macro: KEY_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on every ISSUE.
  - If it reaches TIMEOUT_CYC without gsk_valid_out: err <= 1 (sticky), busy <= 0, key_ready stays 0, state returns to IDLE.
  - err clears on reset or on an accepted start.
- Not defined: no counter, no err port, and WAIT waits indefinitely.

Test Plan:
- Reset, start with key_in=2b7e151628aed2a6abf7158809cf4f3c, generator model of latency 2 -> exactly 10 gsk_valid_in pulses with rcon bytes 01..36 in order; RK[1]=a0fafe1788542cb123a339392a6c7605; RK[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; key_ready rises with busy falling.
- key_in=000102030405060708090a0b0c0d0e0f, generator latencies randomised 1..5 -> RK[10]=13111d7fe3944a17f307a78b4d2b30c5; no second request is issued while one is outstanding.
- start pulsed during round 4, plus a spurious gsk_valid_out in IDLE -> expansion result unchanged; spurious pulse causes no capture.
- reset asserted in round 6 WAIT, then a late gsk_valid_out -> state IDLE, busy=0, key_ready=0; a new start then completes correctly.
- After completion, rk_idx=0 then rk_idx=12 -> rk_data equals key_in one cycle later, then 0 one cycle after that.
- With KEY_SCHED_TIMEOUT_EN, generator never responds -> err=1 at TIMEOUT_CYC cycles into WAIT, busy=0; next start clears err.
